// File: rtl/fwd_pkg.sv
// Shared select codes and pipeline tag-slot type for the operand forwarding unit.
package fwd_pkg;

  localparam logic [1:0] SEL_REG  = 2'd0;
  localparam logic [1:0] SEL_ALU  = 2'd1;
  localparam logic [1:0] SEL_MEM  = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  // Tag destination field is sized for the widest register file we expect;
  // narrower register indices are zero-extended before comparison.
  localparam int TAG_DST_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [TAG_DST_W-1:0] dst;
    logic                 wb_en;
    logic                 is_load;
  } tag_slot_t;

endpackage

// File: rtl/fwd_operand_select.sv
// Resolves one source operand against the EX and MEM tag slots: select code plus load-use hazard flag.
module fwd_operand_select
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  id_valid,
  input  logic                  src_used,
  input  logic [REG_ADDR_W-1:0] src,
  input  tag_slot_t             ex_slot,
  input  tag_slot_t             mem_slot,
  output logic [1:0]            sel,
  output logic                  hazard
);

  logic [TAG_DST_W-1:0] src_ext;
  logic                 ex_hit;
  logic                 mem_hit;
  logic                 unused_mem_is_load;

  assign src_ext            = TAG_DST_W'(src);
  assign ex_hit             = ex_slot.valid  & ex_slot.wb_en  & (ex_slot.dst  == src_ext);
  assign mem_hit            = mem_slot.valid & mem_slot.wb_en & (mem_slot.dst == src_ext);
  assign unused_mem_is_load = mem_slot.is_load;

  // A load in EX has no data yet, so it never forwards; it raises a hazard instead.
  assign hazard = id_valid & src_used & ex_hit & ex_slot.is_load;

  always_comb begin
    sel = SEL_REG;
    if (id_valid && src_used) begin
      if (ex_hit && !ex_slot.is_load) begin
        sel = SEL_ALU;
      end else if (mem_hit) begin
        sel = SEL_MEM;
      end
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// Operand forwarding and load-use stall unit with EX/MEM tag tracking.
// Optional FWD_PERF_CNT_EN adds a saturating 16-bit stall_count output.
module forwarding_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_src1_used,
  input  logic                  id_src2_used,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_wb_en,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            alu_input1_selection,
  output logic [1:0]            alu_input2_selection,
  output logic                  stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  tag_slot_t  ex_slot;
  tag_slot_t  mem_slot;
  tag_slot_t  id_slot;
  logic [1:0] sel1;
  logic [1:0] sel2;
  logic       hazard1;
  logic       hazard2;

  always_comb begin
    id_slot         = '0;
    id_slot.valid   = id_valid;
    id_slot.dst     = TAG_DST_W'(id_dst);
    id_slot.wb_en   = id_wb_en;
    id_slot.is_load = id_is_load;
  end

  fwd_operand_select #(.REG_ADDR_W(REG_ADDR_W)) u_op1 (
    .id_valid (id_valid),
    .src_used (id_src1_used),
    .src      (id_src1),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .sel      (sel1),
    .hazard   (hazard1)
  );

  fwd_operand_select #(.REG_ADDR_W(REG_ADDR_W)) u_op2 (
    .id_valid (id_valid),
    .src_used (id_src2_used),
    .src      (id_src2),
    .ex_slot  (ex_slot),
    .mem_slot (mem_slot),
    .sel      (sel2),
    .hazard   (hazard2)
  );

  // Flush and reset both discard the decode instruction, so neither may hold the front end.
  assign stall = (hazard1 | hazard2) & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ex_slot              <= '0;
      mem_slot             <= '0;
      alu_input1_selection <= SEL_REG;
      alu_input2_selection <= SEL_REG;
    end else if (stall) begin
      ex_slot              <= '0;
      mem_slot             <= ex_slot;
      alu_input1_selection <= SEL_REG;
      alu_input2_selection <= SEL_REG;
    end else begin
      ex_slot              <= id_slot;
      mem_slot             <= ex_slot;
      alu_input1_selection <= sel1;
      alu_input2_selection <= sel2;
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: directed hazard scenarios plus randomized traffic vs. a pipeline model.
module tb_forwarding_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_src1;
  logic [2:0] id_src2;
  logic       id_src1_used;
  logic       id_src2_used;
  logic [2:0] id_dst;
  logic       id_wb_en;
  logic       id_is_load;
  logic       flush;
  logic [1:0] alu_input1_selection;
  logic [1:0] alu_input2_selection;
  logic       stall;
`ifdef FWD_PERF_CNT_EN
  logic [15:0] stall_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit v;
    int dst;
    bit wb;
    bit ld;
  } instr_t;

  // pipe[0] is the instruction in EX, pipe[1] the one in MEM
  instr_t pipe[2];
  int     exp_sel1;
  int     exp_sel2;
  int     exp_count;
  bit     exp_stall;

  forwarding_unit #(.REG_ADDR_W(3)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_valid             (id_valid),
    .id_src1              (id_src1),
    .id_src2              (id_src2),
    .id_src1_used         (id_src1_used),
    .id_src2_used         (id_src2_used),
    .id_dst               (id_dst),
    .id_wb_en             (id_wb_en),
    .id_is_load           (id_is_load),
    .flush                (flush),
    .alu_input1_selection (alu_input1_selection),
    .alu_input2_selection (alu_input2_selection),
    .stall                (stall)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_count          (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Youngest producer of src decides: EX ALU op -> 1, EX load -> hazard, else MEM -> 2.
  function automatic int lookup(input int src, output bit haz);
    haz = 1'b0;
    if (pipe[0].v && pipe[0].wb && pipe[0].dst == src) begin
      if (pipe[0].ld) haz = 1'b1;
      return pipe[0].ld ? 0 : 1;
    end
    if (pipe[1].v && pipe[1].wb && pipe[1].dst == src) return 2;
    return 0;
  endfunction

  task automatic checkVal(input string name, input logic [15:0] act, input int exp);
    vectors++;
    if (act !== 16'(exp)) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("stall", {15'd0, stall}, int'(exp_stall));
    checkVal("sel1", {14'd0, alu_input1_selection}, exp_sel1);
    checkVal("sel2", {14'd0, alu_input2_selection}, exp_sel2);
`ifdef FWD_PERF_CNT_EN
    checkVal("stall_count", stall_count, exp_count);
`endif
  endtask

  task automatic modelReset();
    pipe[0]   = '{0, 0, 0, 0};
    pipe[1]   = '{0, 0, 0, 0};
    exp_sel1  = 0;
    exp_sel2  = 0;
    exp_count = 0;
  endtask

  task automatic applyStimulus(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                               input int d, input bit wb, input bit ld, input bit fl, input bit r);
    bit h1, h2;
    int c1, c2;
    @(negedge clk);
    id_valid     = v;
    id_src1      = 3'(s1);
    id_src1_used = u1;
    id_src2      = 3'(s2);
    id_src2_used = u2;
    id_dst       = 3'(d);
    id_wb_en     = wb;
    id_is_load   = ld;
    flush        = fl;
    rst          = r;
    #1;
    c1 = lookup(s1, h1);
    c2 = lookup(s2, h2);
    exp_stall = !r && !fl && v && ((u1 && h1) || (u2 && h2));
    checkOutput();
    if (r) begin
      modelReset();
    end else if (fl) begin
      pipe[0].v = 1'b0;
      pipe[1].v = 1'b0;
      exp_sel1  = 0;
      exp_sel2  = 0;
    end else if (exp_stall) begin
      pipe[1]  = pipe[0];
      pipe[0]  = '{0, 0, 0, 0};
      exp_sel1 = 0;
      exp_sel2 = 0;
      if (exp_count < 65535) exp_count++;
    end else begin
      pipe[1]  = pipe[0];
      pipe[0]  = '{v, d, wb, ld};
      exp_sel1 = (v && u1) ? c1 : 0;
      exp_sel2 = (v && u2) ? c2 : 0;
    end
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit hold;
    bit rv, ru1, ru2, rwb, rld, rfl, rr;
    int rs1, rs2, rd;

    rst = 1'b1; id_valid = 1'b0; id_src1 = '0; id_src2 = '0;
    id_src1_used = 1'b0; id_src2_used = 1'b0; id_dst = '0;
    id_wb_en = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("reset_sel1", {14'd0, alu_input1_selection}, 0);
    checkVal("reset_sel2", {14'd0, alu_input2_selection}, 0);
    checkVal("reset_stall", {15'd0, stall}, 0);

    // ADD R1 ; ADD R2,R1,R3
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 3, 1, 2, 1, 0, 0, 0);
    checkVal("alu_fwd_stall", {15'd0, stall}, 0);
    nop();
    checkVal("alu_fwd_sel1", {14'd0, alu_input1_selection}, 1);
    checkVal("alu_fwd_sel2", {14'd0, alu_input2_selection}, 0);

    // ADD R1 ; NOP ; SUB R4,R1,R1
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    nop();
    applyStimulus(1, 1, 1, 1, 1, 4, 1, 0, 0, 0);
    checkVal("mem_fwd_stall", {15'd0, stall}, 0);
    nop();
    checkVal("mem_fwd_sel1", {14'd0, alu_input1_selection}, 2);
    checkVal("mem_fwd_sel2", {14'd0, alu_input2_selection}, 2);

    // LOAD R5 ; ADD R6,R5,R0 (held once by the stall)
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 1, 0, 0);
    applyStimulus(1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
    checkVal("load_use_stall", {15'd0, stall}, 1);
    applyStimulus(1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
    checkVal("load_use_stall_once", {15'd0, stall}, 0);
    nop();
    checkVal("load_use_sel1", {14'd0, alu_input1_selection}, 2);

    // ADD R2 ; ADD R2 ; OR R7,R2,R2
    applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    applyStimulus(1, 2, 1, 2, 1, 7, 1, 0, 0, 0);
    nop();
    checkVal("youngest_sel1", {14'd0, alu_input1_selection}, 1);
    checkVal("youngest_sel2", {14'd0, alu_input2_selection}, 1);

    // LOAD R3 ; flush with ADD R4,R3 in decode
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    applyStimulus(1, 3, 1, 0, 0, 4, 1, 0, 1, 0);
    checkVal("flush_stall", {15'd0, stall}, 0);
    applyStimulus(1, 3, 1, 4, 1, 5, 1, 0, 0, 0);
    checkVal("flush_cleared_stall", {15'd0, stall}, 0);
    checkVal("flush_sel1", {14'd0, alu_input1_selection}, 0);
    nop();
    checkVal("flush_tags_sel1", {14'd0, alu_input1_selection}, 0);
    checkVal("flush_tags_sel2", {14'd0, alu_input2_selection}, 0);

    // LOAD R1 ; reset during the would-be stall
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 2, 1, 0, 0, 1);
    checkVal("rst_stall", {15'd0, stall}, 0);
    applyStimulus(1, 1, 1, 1, 1, 3, 1, 0, 0, 0);
    checkVal("post_rst_stall", {15'd0, stall}, 0);
    nop();
    checkVal("post_rst_sel1", {14'd0, alu_input1_selection}, 0);

`ifdef FWD_PERF_CNT_EN
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    end
    checkVal("perf_three", stall_count, 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    nop();
    checkVal("perf_rst", stall_count, 0);
`endif

    // Random traffic; a stalled instruction is usually re-presented like a real held decode.
    hold = 1'b0;
    rv = 0; ru1 = 0; ru2 = 0; rwb = 0; rld = 0; rfl = 0; rr = 0;
    rs1 = 0; rs2 = 0; rd = 0;
    for (int i = 0; i < 600; i++) begin
      if (!(hold && $urandom_range(0, 9) < 8)) begin
        rv  = $urandom_range(0, 9) < 8;
        rs1 = $urandom_range(0, 9) < 8 ? $urandom_range(0, 3) : $urandom_range(0, 7);
        rs2 = $urandom_range(0, 9) < 8 ? $urandom_range(0, 3) : $urandom_range(0, 7);
        ru1 = $urandom_range(0, 9) < 8;
        ru2 = $urandom_range(0, 9) < 6;
        rd  = $urandom_range(0, 3);
        rwb = $urandom_range(0, 9) < 8;
        rld = $urandom_range(0, 9) < 3;
      end
      rfl = $urandom_range(0, 19) == 0;
      rr  = $urandom_range(0, 49) == 0;
      applyStimulus(rv, rs1, ru1, rs2, ru2, rd, rwb, rld, rfl, rr);
      hold = exp_stall;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
